id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Single-entry ID/EX pipeline register directly upstream of the 64-bit ALU.
- Registers decoded operands, decodes the 4-bit ALU opcode from ALUOp plus instruction fields, and sign-extends immediates.
- Presents operand A, operand B and the opcode to the ALU one cycle after acceptance.
- Uses a valid/ready handshake on both sides, plus a flush input for branch squash.

Parameters:
- n, 64, datapath width (operands, immediates, store data).

Ports:
- input_clk  in  1  clock; all state updates on the rising edge.
- input_reset_n  in  1  synchronous, active-low reset.
- input_valid  in  1  upstream presents a decoded instruction.
- output_ready  out  1  stage can accept this cycle.
- input_flush  in  1  squash the held entry.
- input_instruction  in  32  raw LEGv8 instruction word.
- input_read_data_1  in  n  register file port 1.
- input_read_data_2  in  n  register file port 2.
- input_alu_op  in  2  main-control ALUOp.
- input_alu_src  in  1  1 = operand B is the immediate.
- output_valid  out  1  held entry valid.
- input_ready  in  1  downstream (EX) consumes this cycle.
- output_data_1  out  n  ALU operand A.
- output_data_2  out  n  ALU operand B (register or immediate).
- output_opcode  out  4  ALU opcode.
- output_store_data  out  n  registered read_data_2 (STUR data).
- output_imm  out  n  extended immediate (branch offset use).
- output_rd  out  5  instruction[4:0].

Behaviour:
- Reset: when input_reset_n = 0 at a clock edge, every output register clears to 0, including output_valid and output_opcode (4'b0000).
- output_ready is combinational: !output_valid || input_ready.
- Load: on an edge with input_valid && output_ready && !input_flush, all fields capture and output_valid becomes 1.
  - Latency is 1 cycle from acceptance.
  - Back-to-back transfers sustain full throughput.
- Drain: on an edge with output_valid && input_ready and no load, output_valid becomes 0.
- Stall: output_valid && !input_ready holds every output bit-for-bit; upstream sees output_ready = 0.
- Flush: input_flush at an edge clears output_valid to 0 and blocks any simultaneous load. Data registers may hold stale values.
- Priority: reset > flush > load > drain.
- ALU control decode:
  - alu_op 00 → 0010 (LDUR/STUR address add).
  - alu_op 01 → 0111 (CBZ pass-B).
  - alu_op 10 (R-type, instruction[31:21]):
    - 10001011000 → 0010 (ADD)
    - 11001011000 → 0110 (SUB)
    - 10001010000 → 0000 (AND)
    - 10101010000 → 0001 (ORR)
    - any other value → 0010
  - alu_op 11 (I-type, instruction[31:22]):
    - 1001000100 → 0010 (ADDI)
    - 1101000100 → 0110 (SUBI)
    - 1001001000 → 0000 (ANDI)
    - 1011001000 → 0001 (ORRI)
    - any other value → 0010
- Immediate, selected by alu_op:
  - 00: D-type, instruction[20:12], 9-bit, sign-extended to n.
  - 11: I-type, instruction[21:10], 12-bit, zero-extended.
  - 01: CB-type, instruction[23:5], 19-bit, sign-extended.
  - 10: immediate = 0.
- Operand B mux: output_data_2 = alu_src ? imm : read_data_2. output_store_data always takes read_data_2.
- Extension widths are fixed; n < 19 is unsupported.

Optional Feature:
- Macro: ID_EX_ILLEGAL_OP_EN.
- Defined:
  - Adds output port output_illegal (1 bit), registered alongside the other fields and reset to 0.
  - Set to 1 for an accepted entry whose alu_op is 10 or 11 and whose opcode field matches no listed pattern.
  - output_opcode still reads 0010 for such an entry.
  - output_illegal clears on the next load, and with output_valid on flush.
- Undefined: the port is absent, and unmatched patterns silently map to 0010.

Decomposition:
- Shared package constants:
  - ALU opcodes: ALU_ADD = 0010, ALU_SUB = 0110, ALU_AND = 0000, ALU_ORR = 0001, ALU_PASSB = 0111, ALU_NOR = 1100.
  - ALUOp codes.
  - R/I opcode field patterns.
- Sub-module alu_control: combinational; inputs alu_op and instruction[31:21]; outputs opcode and illegal.
- Immediate extension and the handshake register stay inline.

Test Plan:
- ADD: instruction = 0x8B020020 (opcode 10001011000), alu_op = 10, alu_src = 0, rd1 = 5, rd2 = 7, accept → next cycle output_valid = 1, opcode = 0010, data_1 = 5, data_2 = 7, rd = 0.
- LDUR with offset −8: instruction[20:12] = 0x1F8, alu_op = 00, alu_src = 1, rd1 = 0x100 → opcode = 0010, data_2 = 0xFFFF_FFFF_FFFF_FFF8, store_data = rd2.
- SUBI: instruction[31:22] = 1101000100, instruction[21:10] = 0xFFF, alu_op = 11, alu_src = 1 → opcode = 0110, data_2 = 0x0000_0000_0000_0FFF.
- Stall: entry valid, input_ready = 0 for 3 cycles, new input_valid = 1 → output_ready = 0 and all outputs unchanged. input_ready = 1 → pending instruction loads on the same edge.
- Flush vs load: input_flush = 1 with input_valid = 1 and output_ready = 1 → next cycle output_valid = 0. Reset asserted mid-stall → all outputs 0 next edge.
- ID_EX_ILLEGAL_OP_EN: alu_op = 10, instruction[31:21] = 11111111111 → output_illegal = 1, opcode = 0010. The following valid ADD clears output_illegal to 0.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// -----------------------------------------------------------------------------
// id_ex_stage_pkg
// Shared constants for the ID/EX pipeline register and its ALU-control decoder:
//   - alu_ctl_e : 4-bit ALU opcodes presented to the 64-bit ALU
//   - alu_op_e  : 2-bit ALUOp codes produced by main control
//   - OPC_*     : R-type (instruction[31:21]) and I-type (instruction[31:22])
//                 opcode-field patterns recognised by the decoder
// -----------------------------------------------------------------------------
package id_ex_stage_pkg;

   typedef enum logic [3:0] {
      ALU_AND   = 4'b0000,
      ALU_ORR   = 4'b0001,
      ALU_ADD   = 4'b0010,
      ALU_SUB   = 4'b0110,
      ALU_PASSB = 4'b0111,
      ALU_NOR   = 4'b1100
   } alu_ctl_e;

   typedef enum logic [1:0] {
      ALUOP_MEM = 2'b00,   // LDUR/STUR address add, D-type immediate
      ALUOP_CB  = 2'b01,   // CBZ, CB-type immediate
      ALUOP_R   = 2'b10,   // R-type, no immediate
      ALUOP_I   = 2'b11    // I-type, 12-bit zero-extended immediate
   } alu_op_e;

   // R-type patterns, instruction[31:21]
   localparam logic [10:0] OPC_ADD  = 11'b10001011000;
   localparam logic [10:0] OPC_SUB  = 11'b11001011000;
   localparam logic [10:0] OPC_AND  = 11'b10001010000;
   localparam logic [10:0] OPC_ORR  = 11'b10101010000;

   // I-type patterns, instruction[31:22]
   localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
   localparam logic [9:0]  OPC_SUBI = 10'b1101000100;
   localparam logic [9:0]  OPC_ANDI = 10'b1001001000;
   localparam logic [9:0]  OPC_ORRI = 10'b1011001000;

endpackage

// File: rtl/id_ex_stage_if.sv
// -----------------------------------------------------------------------------
// id_ex_stage_if
// Bundles the upstream handshake + decoded-instruction inputs and the
// downstream handshake + ALU-facing outputs of id_ex_stage.
//   slave  : view used by id_ex_stage (consumes input_*, drives output_*)
//   master : view used by whatever drives the stage (decode + EX side)
// Optional: ID_EX_ILLEGAL_OP_EN adds output_illegal.
// Parameter n : datapath width (operands, immediates, store data).
// -----------------------------------------------------------------------------
interface id_ex_stage_if #(
   parameter int n = 64
) ();

   logic          input_valid;
   logic          output_ready;
   logic          input_flush;
   logic [31:0]   input_instruction;
   logic [n-1:0]  input_read_data_1;
   logic [n-1:0]  input_read_data_2;
   logic [1:0]    input_alu_op;
   logic          input_alu_src;
   logic          output_valid;
   logic          input_ready;
   logic [n-1:0]  output_data_1;
   logic [n-1:0]  output_data_2;
   logic [3:0]    output_opcode;
   logic [n-1:0]  output_store_data;
   logic [n-1:0]  output_imm;
   logic [4:0]    output_rd;
`ifdef ID_EX_ILLEGAL_OP_EN
   logic          output_illegal;
`endif

   modport slave (
`ifdef ID_EX_ILLEGAL_OP_EN
      output output_illegal,
`endif
      input  input_valid, input_flush, input_instruction,
      input  input_read_data_1, input_read_data_2,
      input  input_alu_op, input_alu_src, input_ready,
      output output_ready, output_valid,
      output output_data_1, output_data_2, output_opcode,
      output output_store_data, output_imm, output_rd
   );

   modport master (
`ifdef ID_EX_ILLEGAL_OP_EN
      input  output_illegal,
`endif
      output input_valid, input_flush, input_instruction,
      output input_read_data_1, input_read_data_2,
      output input_alu_op, input_alu_src, input_ready,
      input  output_ready, output_valid,
      input  output_data_1, output_data_2, output_opcode,
      input  output_store_data, output_imm, output_rd
   );

endinterface

// File: rtl/id_ex_stage_alu_control.sv
// -----------------------------------------------------------------------------
// alu_control
// Combinational ALU-control decoder.
//   alu_op   in  2   main-control ALUOp
//   op_field in  11  instruction[31:21]
//   opcode   out 4   ALU opcode
//   illegal  out 1   (only with ID_EX_ILLEGAL_OP_EN) R/I pattern unmatched
// Unmatched R/I patterns fall back to ADD.
// -----------------------------------------------------------------------------
module alu_control
   import id_ex_stage_pkg::*;
(
`ifdef ID_EX_ILLEGAL_OP_EN
   output logic        illegal,
`endif
   input  logic [1:0]  alu_op,
   input  logic [10:0] op_field,
   output logic [3:0]  opcode
);

   always_comb begin
      opcode = ALU_ADD;
`ifdef ID_EX_ILLEGAL_OP_EN
      illegal = 1'b0;
`endif
      case (alu_op)
         ALUOP_MEM: opcode = ALU_ADD;
         ALUOP_CB:  opcode = ALU_PASSB;
         ALUOP_R: begin
            case (op_field)
               OPC_ADD: opcode = ALU_ADD;
               OPC_SUB: opcode = ALU_SUB;
               OPC_AND: opcode = ALU_AND;
               OPC_ORR: opcode = ALU_ORR;
               default: begin
                  opcode = ALU_ADD;
`ifdef ID_EX_ILLEGAL_OP_EN
                  illegal = 1'b1;
`endif
               end
            endcase
         end
         ALUOP_I: begin
            // I-type opcodes are only 10 bits; bit 21 belongs to the immediate
            case (op_field[10:1])
               OPC_ADDI: opcode = ALU_ADD;
               OPC_SUBI: opcode = ALU_SUB;
               OPC_ANDI: opcode = ALU_AND;
               OPC_ORRI: opcode = ALU_ORR;
               default: begin
                  opcode = ALU_ADD;
`ifdef ID_EX_ILLEGAL_OP_EN
                  illegal = 1'b1;
`endif
               end
            endcase
         end
         default: opcode = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// Single-entry ID/EX pipeline register feeding the 64-bit ALU. Decodes the ALU
// opcode, extends the immediate, selects operand B and holds the result under
// a valid/ready handshake, with a flush input for branch squash.
//   input_clk      in  1   rising-edge clock
//   input_reset_n  in  1   synchronous active-low reset (clears every output)
//   bus            slave modport of id_ex_stage_if (handshakes, operands,
//                  instruction, ALU-facing outputs)
// Parameter n : datapath width, must be >= 19.
// Optional macro ID_EX_ILLEGAL_OP_EN : adds registered output_illegal.
// -----------------------------------------------------------------------------
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int n = 64
) (
   input  logic         input_clk,
   input  logic         input_reset_n,
   id_ex_stage_if.slave bus
);

   logic [31:0]  instr;
   logic [3:0]   opcode_c;
   logic [n-1:0] imm_c;
   logic [n-1:0] opb_c;
   logic         ready;
   logic         load;

   logic         vld_p1;
   logic [n-1:0] data_1_p1;
   logic [n-1:0] data_2_p1;
   logic [3:0]   opcode_p1;
   logic [n-1:0] store_p1;
   logic [n-1:0] imm_p1;
   logic [4:0]   rd_p1;
`ifdef ID_EX_ILLEGAL_OP_EN
   logic         illegal_c;
   logic         illegal_p1;
`endif

   assign instr = bus.input_instruction;

   // ---- decode stage (combinational, ahead of the register) ----
   alu_control u_alu_control (
`ifdef ID_EX_ILLEGAL_OP_EN
      .illegal  (illegal_c),
`endif
      .alu_op   (bus.input_alu_op),
      .op_field (instr[31:21]),
      .opcode   (opcode_c)
   );

   always_comb begin
      imm_c = '0;
      case (bus.input_alu_op)
         ALUOP_MEM: imm_c = {{(n-9){instr[20]}}, instr[20:12]};
         ALUOP_I:   imm_c = {{(n-12){1'b0}}, instr[21:10]};
         ALUOP_CB:  imm_c = {{(n-19){instr[23]}}, instr[23:5]};
         default:   imm_c = '0;
      endcase
   end

   assign opb_c = bus.input_alu_src ? imm_c : bus.input_read_data_2;

   // A stalled entry releases the slot in the same cycle EX consumes it.
   assign ready = !vld_p1 || bus.input_ready;
   assign load  = bus.input_valid && ready && !bus.input_flush;

   // ---- p1: ID/EX register ----
   always_ff @(posedge input_clk) begin
      if (!input_reset_n) begin
         vld_p1     <= 1'b0;
         data_1_p1  <= '0;
         data_2_p1  <= '0;
         opcode_p1  <= '0;
         store_p1   <= '0;
         imm_p1     <= '0;
         rd_p1      <= '0;
`ifdef ID_EX_ILLEGAL_OP_EN
         illegal_p1 <= 1'b0;
`endif
      end else if (bus.input_flush) begin
         // data registers keep stale values; only validity is squashed
         vld_p1     <= 1'b0;
`ifdef ID_EX_ILLEGAL_OP_EN
         illegal_p1 <= 1'b0;
`endif
      end else if (load) begin
         vld_p1     <= 1'b1;
         data_1_p1  <= bus.input_read_data_1;
         data_2_p1  <= opb_c;
         opcode_p1  <= opcode_c;
         store_p1   <= bus.input_read_data_2;
         imm_p1     <= imm_c;
         rd_p1      <= instr[4:0];
`ifdef ID_EX_ILLEGAL_OP_EN
         illegal_p1 <= illegal_c;
`endif
      end else if (vld_p1 && bus.input_ready) begin
         vld_p1     <= 1'b0;
      end
   end

   assign bus.output_ready      = ready;
   assign bus.output_valid      = vld_p1;
   assign bus.output_data_1     = data_1_p1;
   assign bus.output_data_2     = data_2_p1;
   assign bus.output_opcode     = opcode_p1;
   assign bus.output_store_data = store_p1;
   assign bus.output_imm        = imm_p1;
   assign bus.output_rd         = rd_p1;
`ifdef ID_EX_ILLEGAL_OP_EN
   assign bus.output_illegal    = illegal_p1;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
// Directed self-checking bench for id_ex_stage (n = 64). Inputs change 2 time
// units after the rising edge; outputs are sampled at the same point.
// Build with ID_EX_ILLEGAL_OP_EN defined to exercise output_illegal.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

   localparam int N = 64;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   id_ex_stage_if #(.n(N)) bus ();

   id_ex_stage #(.n(N)) dut (
      .input_clk     (clk),
      .input_reset_n (rst_n),
      .bus           (bus)
   );

   // {valid, opcode, data_1, data_2, store_data, imm, rd}
   function automatic logic [265:0] obs();
      return {bus.output_valid, bus.output_opcode, bus.output_data_1,
              bus.output_data_2, bus.output_store_data, bus.output_imm,
              bus.output_rd};
   endfunction

   localparam logic [265:0] EXP_ADD =
      {1'b1, 4'b0010, 64'd5, 64'd7, 64'd7, 64'd0, 5'd0};
   localparam logic [265:0] EXP_SUB =
      {1'b1, 4'b0110, 64'd9, 64'd3, 64'd3, 64'd0, 5'd0};

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic v, input logic [31:0] ins,
                        input logic [63:0] r1, input logic [63:0] r2,
                        input logic [1:0] op, input logic src);
      bus.input_valid       = v;
      bus.input_instruction = ins;
      bus.input_read_data_1 = r1;
      bus.input_read_data_2 = r2;
      bus.input_alu_op      = op;
      bus.input_alu_src     = src;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.input_flush = 1'b0;
      bus.input_ready = 1'b0;
      drive(1'b1, 32'h8B020020, 64'd5, 64'd7, 2'b10, 1'b0);
      tick();
      tick();
      checks++;
      if (obs() !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected 0", obs());
      end
      checks++;
      if (bus.output_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got %b expected 1", bus.output_ready);
      end
`ifdef ID_EX_ILLEGAL_OP_EN
      checks++;
      if (bus.output_illegal !== 1'b0) begin
         errors++;
         $display("FAIL reset_illegal: got %b expected 0", bus.output_illegal);
      end
`endif
      drive(1'b0, 32'h0, 64'd0, 64'd0, 2'b00, 1'b0);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_add();
      drive(1'b1, 32'h8B020020, 64'd5, 64'd7, 2'b10, 1'b0);
      #1;
      checks++;
      if (bus.output_ready !== 1'b1) begin
         errors++;
         $display("FAIL add_ready: got %b expected 1", bus.output_ready);
      end
      tick();
      drive(1'b0, 32'h0, 64'd0, 64'd0, 2'b00, 1'b0);
      checks++;
      if (obs() !== EXP_ADD) begin
         errors++;
         $display("FAIL add_fields: got %h expected %h", obs(), EXP_ADD);
      end
      // held while EX is not ready, then drained
      tick();
      checks++;
      if (bus.output_valid !== 1'b1) begin
         errors++;
         $display("FAIL add_hold_valid: got %b expected 1", bus.output_valid);
      end
      bus.input_ready = 1'b1;
      tick();
      checks++;
      if (bus.output_valid !== 1'b0) begin
         errors++;
         $display("FAIL add_drain: got %b expected 0", bus.output_valid);
      end
   endtask

   task automatic test_ldur_subi();
      logic [265:0] exp_v;
      bus.input_ready = 1'b1;
      drive(1'b1, 32'hF85F8003, 64'h100, 64'hDEAD, 2'b00, 1'b1);
      tick();
      exp_v = {1'b1, 4'b0010, 64'h100, 64'hFFFF_FFFF_FFFF_FFF8, 64'hDEAD,
               64'hFFFF_FFFF_FFFF_FFF8, 5'd3};
      checks++;
      if (obs() !== exp_v) begin
         errors++;
         $display("FAIL ldur_fields: got %h expected %h", obs(), exp_v);
      end
      drive(1'b1, 32'hD13FFC01, 64'h11, 64'h22, 2'b11, 1'b1);
      tick();
      drive(1'b0, 32'h0, 64'd0, 64'd0, 2'b00, 1'b0);
      exp_v = {1'b1, 4'b0110, 64'h11, 64'h0FFF, 64'h22, 64'h0FFF, 5'd1};
      checks++;
      if (obs() !== exp_v) begin
         errors++;
         $display("FAIL subi_fields: got %h expected %h", obs(), exp_v);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [31:0] ins [10]  = '{32'h8A000000, 32'hAA000000, 32'hCB000000,
                                 32'hFFE00000, 32'h91000000, 32'h92000000,
                                 32'hB2000000, 32'hB4FFFFE0, 32'hF84FF000,
                                 32'h91200000};
      logic [1:0]  op [10]   = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11,
                                 2'b11, 2'b01, 2'b00, 2'b11};
      logic [3:0]  eop [10]  = '{4'b0000, 4'b0001, 4'b0110, 4'b0010, 4'b0010,
                                 4'b0000, 4'b0001, 4'b0111, 4'b0010, 4'b0010};
      logic [63:0] eimm [10] = '{64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0,
                                 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0FF,
                                 64'h800};
`ifdef ID_EX_ILLEGAL_OP_EN
      logic        eill [10] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
`endif
      bus.input_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, ins[i], 64'(i + 1), 64'(100 + i), op[i], 1'b1);
         tick();
         checks++;
         if (bus.output_valid !== 1'b1 || bus.output_opcode !== eop[i] ||
             bus.output_data_2 !== eimm[i] ||
             bus.output_data_1 !== 64'(i + 1) ||
             bus.output_store_data !== 64'(100 + i)) begin
            errors++;
            $display("FAIL b2b_%0d: got v=%b op=%b d1=%h d2=%h sd=%h expected v=1 op=%b d1=%h d2=%h sd=%h",
                     i, bus.output_valid, bus.output_opcode, bus.output_data_1,
                     bus.output_data_2, bus.output_store_data, eop[i],
                     64'(i + 1), eimm[i], 64'(100 + i));
         end
`ifdef ID_EX_ILLEGAL_OP_EN
         checks++;
         if (bus.output_illegal !== eill[i]) begin
            errors++;
            $display("FAIL b2b_illegal_%0d: got %b expected %b",
                     i, bus.output_illegal, eill[i]);
         end
`endif
      end
      drive(1'b0, 32'h0, 64'd0, 64'd0, 2'b00, 1'b0);
      tick();
   endtask

   task automatic test_stall();
      bus.input_ready = 1'b1;
      drive(1'b1, 32'h8B020020, 64'd5, 64'd7, 2'b10, 1'b0);
      tick();
      bus.input_ready = 1'b0;
      drive(1'b1, 32'hCB000000, 64'd9, 64'd3, 2'b10, 1'b0);
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (bus.output_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_ready_%0d: got %b expected 0", c, bus.output_ready);
         end
         tick();
         checks++;
         if (obs() !== EXP_ADD) begin
            errors++;
            $display("FAIL stall_hold_%0d: got %h expected %h", c, obs(), EXP_ADD);
         end
      end
      bus.input_ready = 1'b1;
      #1;
      checks++;
      if (bus.output_ready !== 1'b1) begin
         errors++;
         $display("FAIL stall_release_ready: got %b expected 1", bus.output_ready);
      end
      tick();
      drive(1'b0, 32'h0, 64'd0, 64'd0, 2'b00, 1'b0);
      checks++;
      if (obs() !== EXP_SUB) begin
         errors++;
         $display("FAIL stall_release_load: got %h expected %h", obs(), EXP_SUB);
      end
      tick();
   endtask

   task automatic test_flush();
      // flush beats a load that would otherwise be accepted
      bus.input_ready = 1'b1;
      drive(1'b1, 32'h8B020020, 64'd5, 64'd7, 2'b10, 1'b0);
      tick();
      bus.input_flush = 1'b1;
      drive(1'b1, 32'hCB000000, 64'd9, 64'd3, 2'b10, 1'b0);
      #1;
      checks++;
      if (bus.output_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_ready: got %b expected 1", bus.output_ready);
      end
      tick();
      bus.input_flush = 1'b0;
      drive(1'b0, 32'h0, 64'd0, 64'd0, 2'b00, 1'b0);
      checks++;
      if (bus.output_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_vs_load: got valid %b expected 0", bus.output_valid);
      end
      // flush of a stalled entry
      drive(1'b1, 32'h8B020020, 64'd5, 64'd7, 2'b10, 1'b0);
      tick();
      drive(1'b0, 32'h0, 64'd0, 64'd0, 2'b00, 1'b0);
      bus.input_ready = 1'b0;
      bus.input_flush = 1'b1;
      tick();
      bus.input_flush = 1'b0;
      checks++;
      if (bus.output_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_stalled: got valid %b expected 0", bus.output_valid);
      end
      // reset while stalled with a pending upstream instruction
      drive(1'b1, 32'h8B020020, 64'd5, 64'd7, 2'b10, 1'b0);
      tick();
      drive(1'b1, 32'hCB000000, 64'd9, 64'd3, 2'b10, 1'b0);
      tick();
      rst_n = 1'b0;
      tick();
      checks++;
      if (obs() !== '0) begin
         errors++;
         $display("FAIL reset_mid_stall: got %h expected 0", obs());
      end
      rst_n = 1'b1;
      drive(1'b0, 32'h0, 64'd0, 64'd0, 2'b00, 1'b0);
      tick();
   endtask

`ifdef ID_EX_ILLEGAL_OP_EN
   task automatic test_illegal();
      bus.input_ready = 1'b1;
      drive(1'b1, 32'hFFE00000, 64'd1, 64'd2, 2'b10, 1'b0);
      tick();
      checks++;
      if (bus.output_illegal !== 1'b1 || bus.output_opcode !== 4'b0010) begin
         errors++;
         $display("FAIL illegal_r: got ill=%b op=%b expected ill=1 op=0010",
                  bus.output_illegal, bus.output_opcode);
      end
      drive(1'b1, 32'h8B020020, 64'd5, 64'd7, 2'b10, 1'b0);
      tick();
      checks++;
      if (bus.output_illegal !== 1'b0 || bus.output_opcode !== 4'b0010) begin
         errors++;
         $display("FAIL illegal_clear_on_load: got ill=%b op=%b expected ill=0 op=0010",
                  bus.output_illegal, bus.output_opcode);
      end
      drive(1'b1, 32'hFFC00000, 64'd1, 64'd2, 2'b11, 1'b1);
      tick();
      checks++;
      if (bus.output_illegal !== 1'b1 || bus.output_opcode !== 4'b0010) begin
         errors++;
         $display("FAIL illegal_i: got ill=%b op=%b expected ill=1 op=0010",
                  bus.output_illegal, bus.output_opcode);
      end
      drive(1'b0, 32'h0, 64'd0, 64'd0, 2'b00, 1'b0);
      bus.input_ready = 1'b0;
      bus.input_flush = 1'b1;
      tick();
      bus.input_flush = 1'b0;
      checks++;
      if (bus.output_illegal !== 1'b0 || bus.output_valid !== 1'b0) begin
         errors++;
         $display("FAIL illegal_flush: got ill=%b v=%b expected ill=0 v=0",
                  bus.output_illegal, bus.output_valid);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_add();
      test_ldur_subi();
      test_back_to_back();
      test_stall();
      test_flush();
`ifdef ID_EX_ILLEGAL_OP_EN
      test_illegal();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
